alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Parametrised next-generation execute unit for the MIPS core.
- Single-cycle combinational ALU operations:
  - add, sub, bitwise and/or/xor/nor, slt, sltu.
- Iterative multi-cycle multiply/divide engine with architectural HI/LO registers:
  - mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
- Sits in EX stage. Controller stalls the pipeline while busy=1.

Parameters:
- WIDTH, 32, datapath width. Even, ≥4. HI/LO are WIDTH each; the product is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- srca  in  WIDTH  operand A (rs)
- srcb  in  WIDTH  operand B (rt)
- alucontrol  in  4  operation select
- start  in  1  launch op 8–11, or write op 14–15. Sampled at clk edge.
- aluresult  out  WIDTH  combinational result
- zero  out  1  combinational, aluresult==0 for ops 0–7, else 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  multiply/divide in progress
- done  out  1  one-cycle pulse: HI/LO just updated by mult/div

Behaviour:
- Opcodes:
  - 0 add, 1 sub (modulo 2^WIDTH, no overflow trap)
  - 2 and, 3 or, 4 xor, 5 nor (all bitwise, not logical)
  - 6 slt (signed compare), 7 sltu (unsigned compare); result is zero-extended 0/1
  - 8 mult, 9 multu, 10 div, 11 divu
  - 12 mfhi, 13 mflo, 14 mthi, 15 mtlo
- aluresult per opcode:
  - ops 0–7: combinational from srca/srcb.
  - op 12: hi. op 13: lo.
  - ops 8–11, 14–15: 0.
  - While busy, mfhi/mflo return the old register value; stalling is the controller's job.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE. Internal accumulators and counter cleared.
- Reset mid-operation:
  - Aborts the operation; hi/lo are cleared.
  - No done pulse.
  - Reset has priority over start.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE, start=1, op 8/9: latch operands (operands are converted to magnitudes first; for the unsigned ops the conversion is a pass-through), record result signs, counter=0, go to MUL, busy=1.
  - IDLE, start=1, op 10/11: same latching, go to DIV, busy=1.
  - IDLE, start=1, op 14: hi<=srca next edge. Op 15: lo<=srca next edge. No busy, no done.
  - IDLE, start=1, ops 0–7 or 12–13: ignored.
  - MUL: one shift-add step per cycle on magnitudes, WIDTH steps, then go to FIX.
  - DIV: one restoring shift-subtract step per cycle, WIDTH steps, then go to FIX.
  - FIX: apply sign correction, write {hi,lo}, done=1 for exactly one cycle, busy=0 in the same cycle, return to IDLE.
- Latency:
  - start sampled at edge E0; busy=1 from E0 through E(WIDTH+1).
  - hi/lo updated and done=1 after edge E(WIDTH+1), i.e. WIDTH+1 cycles after launch.
- start while busy=1 is ignored for all ops, including mthi/mtlo. Operands are held internally, so srca/srcb may change after E0.
- A new start may be accepted in the cycle done=1.
- Multiply result:
  - {hi,lo} = full 2*WIDTH product.
  - Signed: two's complement of the magnitude product when the operand signs differ.
- Divide result: lo = quotient, hi = remainder.
  - Signed: quotient truncated toward zero; remainder takes the sign of the dividend.
  - Overflow case, most-negative / -1: lo = most-negative, hi = 0.
  - Divide by zero, signed and unsigned: lo = all ones, hi = dividend. Same latency, no error flag.

Test Plan:
- add 0x7FFFFFFF+1 → aluresult=0x80000000, zero=0.
- sub 5-5 → aluresult=0, zero=1.
- slt 0xFFFFFFFF,1 → 1. sltu on the same operands → 0.
- and 0xF0,0x3C → 0x30 (not 1).
- mult 0xFFFFFFFD×5 with start → busy for 33 cycles, then done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu 0xFFFFFFFF×2 → hi=1, lo=0xFFFFFFFE.
- div -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 7/0 → lo=0xFFFFFFFF, hi=7.
- div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Reset at cycle 10 of a mult → busy=0, hi=lo=0, no done pulse.
- Then mtlo 0x1234 → lo=0x1234 next cycle; mflo returns 0x1234.
- start mthi 0xAAAA while busy → ignored; hi equals the mult result after done.
- Back-to-back: start a second op in the done cycle → accepted; busy stays 1.

Source files
------------

// File: rtl/alu_muldiv_if.sv
// EX-stage execute-unit bus: operands, op select and launch strobe in; result, HI/LO, busy/done out.
// The master drives operands and start; the slave (alu_muldiv) returns the results and status.
interface alu_muldiv_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [3:0]       alucontrol;
  logic             start;
  logic [WIDTH-1:0] aluresult;
  logic             zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output srca, srcb, alucontrol, start,
    input  aluresult, zero, hi, lo, busy, done
  );

  modport slave (
    input  srca, srcb, alucontrol, start,
    output aluresult, zero, hi, lo, busy, done
  );
endinterface

// File: rtl/alu_muldiv.sv
// MIPS EX unit: combinational ALU plus an iterative mul/div with HI/LO; mul/div results land WIDTH+1 cycles after launch.
// While busy, every start is dropped; the controller stalls on busy, and done pulses for one cycle as HI/LO update.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  alu_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state_q, state_d;
  logic [3:0]         op;
  logic [WIDTH-1:0]   a, b;
  logic               md_op, div_op, sgn_op, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q, hi_q, lo_q;
  logic               neg_q, neg_rem_q, dz_q, is_div_q, done_q;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem, rem, quo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res;

  assign op = bus.alucontrol;
  assign a  = bus.srca;
  assign b  = bus.srcb;

  // Ops 8..11 launch the engine; even opcodes among them are the signed variants.
  assign md_op  = op[3] & ~op[2];
  assign div_op = op[1];
  assign sgn_op = ~op[0];
  assign sa     = sgn_op & a[WIDTH-1];
  assign sb     = sgn_op & b[WIDTH-1];
  assign mag_a  = sa ? -a : a;
  assign mag_b  = sb ? -b : b;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.start && md_op) state_d = div_op ? DIV : MUL;
      MUL, DIV: if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      FIX:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // acc_q holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ok    = div_shift >= {1'b0, opb_q};
  assign div_rem   = div_shift[WIDTH-1:0] - opb_q;
  assign rem       = acc_q[2*WIDTH-1:WIDTH];
  assign quo       = acc_q[WIDTH-1:0];
  assign prod_fix  = neg_q ? -acc_q : acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      is_div_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (md_op) begin
              acc_q     <= {{WIDTH{1'b0}}, mag_a};
              opb_q     <= mag_b;
              cnt_q     <= '0;
              neg_q     <= sa ^ sb;
              neg_rem_q <= sa;
              dz_q      <= (b == '0);
              is_div_q  <= div_op;
            end else if (op == 4'd14) begin
              hi_q <= a;
            end else if (op == 4'd15) begin
              lo_q <= a;
            end
          end
        end
        MUL: begin
          acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CW'(1);
        end
        DIV: begin
          acc_q <= {(div_ok ? div_rem : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ok};
          cnt_q <= cnt_q + CW'(1);
        end
        FIX: begin
          // Divide-by-zero keeps the dividend in HI via the remainder path; only LO is forced.
          if (is_div_q) begin
            hi_q <= neg_rem_q ? -rem : rem;
            lo_q <= dz_q ? {WIDTH{1'b1}} : (neg_q ? -quo : quo);
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    res = '0;
    case (op)
      4'd0:    res = a + b;
      4'd1:    res = a - b;
      4'd2:    res = a & b;
      4'd3:    res = a | b;
      4'd4:    res = a ^ b;
      4'd5:    res = ~(a | b);
      4'd6:    res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd7:    res = {{(WIDTH-1){1'b0}}, (a < b)};
      4'd12:   res = hi_q;
      4'd13:   res = lo_q;
      default: res = '0;
    endcase
  end

  assign bus.aluresult = res;
  assign bus.zero      = ~op[3] & (res == '0);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised bench for alu_muldiv: mul/div results go through a queue checked on each done pulse,
// ALU results are compared against an arithmetic model of the MIPS instruction semantics.
module tb_alu_muldiv;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_muldiv_if #(.WIDTH(W)) bus ();
  alu_muldiv #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int          checks = 0;
  int          errors = 0;
  int          busy_cnt = 0;
  int          n_done = 0;
  logic [63:0] expq[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      4'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:    return (a < b) ? 32'd1 : 32'd0;
      4'd12:   return m_hi;
      4'd13:   return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  // Returns {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd8: return sa * sb;
      4'd9: return ua * ub;
      4'd10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = ua / ub;
        r = ua % ub;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops an expected {hi,lo} on each done pulse.
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset) begin
      busy_cnt = 0;
    end else if (bus.done) begin
      n_done++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        e = expq.pop_front();
        chk("md_hi", 64'(bus.hi), 64'(e[63:32]));
        chk("md_lo", 64'(bus.lo), 64'(e[31:0]));
        chk("busy_len", 64'(busy_cnt), 64'(W + 1));
        chk("busy_at_done", 64'(bus.busy), 64'd0);
        m_hi = e[63:32];
        m_lo = e[31:0];
      end
      busy_cnt = 0;
    end else if (bus.busy) begin
      busy_cnt++;
    end
  end

  task automatic alu_check(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e;
    @(negedge clk);
    bus.alucontrol = op;
    bus.srca       = a;
    bus.srcb       = b;
    bus.start      = 1'b0;
    #1;
    e = ref_alu(op, a, b);
    chk($sformatf("alu_op%0d", op), 64'(bus.aluresult), 64'(e));
    chk("zero", 64'(bus.zero), 64'((op < 4'd8) && (e == 32'd0)));
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    bus.alucontrol = op;
    bus.srca       = a;
    bus.srcb       = b;
    bus.start      = 1'b1;
    if (push) expq.push_back(ref_md(op, a, b));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.srca  = $urandom;
    bus.srcb  = $urandom;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < W + 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", W + 10);
    end
  endtask

  task automatic do_reset();
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    expq.delete();
    m_hi = '0;
    m_lo = '0;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nd;
    logic [3:0]  op;
    logic [31:0] v;
    bus.start      = 1'b0;
    bus.alucontrol = '0;
    bus.srca       = '0;
    bus.srcb       = '0;
    do_reset();

    alu_check(4'd0, 32'h7FFF_FFFF, 32'd1);
    chk("tp_add", 64'(bus.aluresult), 64'h8000_0000);
    alu_check(4'd1, 32'd5, 32'd5);
    chk("tp_sub_zero", 64'(bus.zero), 64'd1);
    alu_check(4'd6, 32'hFFFF_FFFF, 32'd1);
    chk("tp_slt", 64'(bus.aluresult), 64'd1);
    alu_check(4'd7, 32'hFFFF_FFFF, 32'd1);
    chk("tp_sltu", 64'(bus.aluresult), 64'd0);
    alu_check(4'd2, 32'hF0, 32'h3C);
    chk("tp_and", 64'(bus.aluresult), 64'h30);

    issue(4'd8, 32'hFFFF_FFFD, 32'd5, 1'b1);
    alu_check(4'd12, 32'd0, 32'd0);
    wait_done();
    chk("tp_mult", {32'd0, bus.hi} << 32 | 64'(bus.lo), 64'hFFFF_FFFF_FFFF_FFF1);
    issue(4'd9, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_done();
    chk("tp_multu", {32'd0, bus.hi} << 32 | 64'(bus.lo), 64'h0000_0001_FFFF_FFFE);
    issue(4'd10, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done();
    chk("tp_div", {32'd0, bus.hi} << 32 | 64'(bus.lo), 64'hFFFF_FFFF_FFFF_FFFD);
    issue(4'd11, 32'd7, 32'd0, 1'b1);
    wait_done();
    chk("tp_divu_zero", {32'd0, bus.hi} << 32 | 64'(bus.lo), 64'h0000_0007_FFFF_FFFF);
    issue(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done();
    chk("tp_div_ovf", {32'd0, bus.hi} << 32 | 64'(bus.lo), 64'h0000_0000_8000_0000);
    issue(4'd10, 32'hFFFF_FFF9, 32'd0, 1'b1);
    wait_done();

    // Reset ten cycles into a multiply: no done must ever follow.
    issue(4'd8, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    nd = n_done;
    do_reset();
    repeat (W + 5) @(posedge clk);
    chk("abort_no_done", 64'(n_done), 64'(nd));

    @(negedge clk);
    issue(4'd15, 32'h1234, 32'd0, 1'b0);
    m_lo = 32'h1234;
    chk("tp_mtlo", 64'(bus.lo), 64'h1234);
    alu_check(4'd13, 32'd0, 32'd0);

    issue(4'd8, 32'h0001_0000, 32'h0003_0000, 1'b1);
    issue(4'd14, 32'hAAAA, 32'd0, 1'b0);
    wait_done();
    chk("tp_mthi_busy", 64'(bus.hi), 64'd3);
    alu_check(4'd12, 32'd0, 32'd0);

    issue(4'd9, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);
    wait_done();
    issue(4'd11, 32'hDEAD_BEEF, 32'd17, 1'b1);
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done();

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          op = 4'($urandom_range(0, 9));
          if (op > 4'd7) op = op + 4'd4;
          alu_check(op, rnd(), rnd());
        end
        2: begin
          op = 4'd8 + 4'($urandom_range(0, 3));
          issue(op, rnd(), rnd(), 1'b1);
          alu_check(4'd12, rnd(), rnd());
          alu_check(4'($urandom_range(0, 7)), rnd(), rnd());
          wait_done();
          alu_check(4'd13, 32'd0, 32'd0);
        end
        default: begin
          op = 4'd14 + 4'($urandom_range(0, 1));
          v  = rnd();
          @(negedge clk);
          issue(op, v, rnd(), 1'b0);
          if (op == 4'd14) m_hi = v;
          else m_lo = v;
          alu_check(op - 4'd2, 32'd0, 32'd0);
        end
      endcase
    end

    repeat (2) @(posedge clk);
    chk("queue_empty", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
